// File: rtl/mem_pkg.sv
// mem_pkg: shared types and op decoding for the MEM-stage load/store engine
package mem_pkg;
  typedef enum logic [3:0] {NONE, LB, LBU, LH, LHU, LW, SB, SH, SW} mem_op_t;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} mem_state_t;

  function automatic logic is_load(mem_op_t op);
    return op == LB || op == LBU || op == LH || op == LHU || op == LW;
  endfunction

  function automatic logic is_store(mem_op_t op);
    return op == SB || op == SH || op == SW;
  endfunction

  // 0 = byte, 1 = half, 2 = word
  function automatic logic [1:0] access_size(mem_op_t op);
    return (op == LW || op == SW) ? 2'd2 : (op == LH || op == LHU || op == SH) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for store enables/data and load extraction
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int LANE_BITS = $clog2(NB)
) (
  input  mem_op_t               op,
  input  logic [LANE_BITS-1:0]  lane,
  input  logic [31:0]           wdata,
  input  logic [DATA_W-1:0]     bus,
  output logic [NB-1:0]         be,
  output logic [DATA_W-1:0]     bwdata,
  output logic [31:0]           rdata
);
  logic [1:0] size;
  logic [31:0] shifted;
  logic sx;

  // replicate store data across all lanes, shift enables and load data by lane
  always_comb begin
    size = access_size(op);
    sx = op == LB || op == LH;
    be = NB'(size == 2'd2 ? 4'hF : size == 2'd1 ? 4'h3 : 4'h1) << lane;
    bwdata = size == 2'd2 ? {(DATA_W/32){wdata}} :
             size == 2'd1 ? {(DATA_W/16){wdata[15:0]}} : {NB{wdata[7:0]}};
    shifted = 32'(bus >> {lane, 3'b000});
    rdata = size == 2'd2 ? shifted :
            size == 2'd1 ? {{16{sx && shifted[15]}}, shifted[15:0]} :
                           {{24{sx && shifted[7]}}, shifted[7:0]};
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store engine on a split addr/data handshake bus
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic [3:0]          op_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [31:0]         wdata_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic [31:0]         rdata_o,
  output logic                rdata_valid_o,
  output logic                adel_o,
  output logic                ades_o,
  output logic [ADDR_W-1:0]   bad_vaddr_o,
  output logic                req_o,
  output logic                we_o,
  output logic [ADDR_W-1:0]   baddr_o,
  output logic [DATA_W/8-1:0] be_o,
  output logic [DATA_W-1:0]   bwdata_o,
  input  logic                addr_ok_i,
  input  logic                data_ok_i,
  input  logic [DATA_W-1:0]   brdata_i
);
  localparam int NB = DATA_W / 8;
  localparam int LANE_BITS = $clog2(NB);

  mem_state_t state;
  mem_op_t op_in, op_q, op_sel;
  logic [ADDR_W-1:0] addr_q;
  logic [LANE_BITS-1:0] lane_sel;
  logic [NB-1:0] be_q, al_be;
  logic [DATA_W-1:0] bwdata_q, al_bwdata;
  logic [31:0] rdata_q, al_rdata;
  logic check, misal, accept, to_done;

  // in IDLE the aligner sees the incoming op for store prep; otherwise the latched op for load return
  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .op(op_sel), .lane(lane_sel), .wdata(wdata_i), .bus(brdata_i),
    .be(al_be), .bwdata(al_bwdata), .rdata(al_rdata)
  );

  // alignment check, accept decision, stall and bus outputs
  always_comb begin
    op_in = mem_op_t'(op_i);
    op_sel = state == IDLE ? op_in : op_q;
    lane_sel = state == IDLE ? addr_i[LANE_BITS-1:0] : addr_q[LANE_BITS-1:0];
    check = !rst_i && state == IDLE && valid_i;
    misal = access_size(op_in) == 2'd2 ? addr_i[1:0] != 2'b00 : access_size(op_in) == 2'd1 && addr_i[0];
    adel_o = check && misal && is_load(op_in);
    ades_o = check && misal && is_store(op_in);
    bad_vaddr_o = (adel_o || ades_o) ? addr_i : '0;
    accept = check && !misal && !flush_i && (is_load(op_in) || is_store(op_in));
    to_done = !flush_i && data_ok_i && (state == WAIT || (state == REQ && addr_ok_i));
    stall_o = accept || state == WAIT || state == DRAIN || (state == REQ && !(flush_i && !addr_ok_i));
    req_o = state == REQ;
    we_o = req_o && is_store(op_q);
    baddr_o = req_o ? {addr_q[ADDR_W-1:LANE_BITS], {LANE_BITS{1'b0}}} : '0;
    be_o = req_o ? be_q : '0;
    bwdata_o = req_o ? bwdata_q : '0;
    rdata_valid_o = state == DONE && is_load(op_q);
    rdata_o = rdata_q;
  end

  // transfer FSM; a flush after the address phase must still drain the data phase
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      op_q <= NONE;
      addr_q <= '0;
      be_q <= '0;
      bwdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        op_q <= op_in;
        addr_q <= addr_i;
        be_q <= al_be;
        bwdata_q <= al_bwdata;
      end
      if (to_done && is_load(op_q)) rdata_q <= al_rdata;
      case (state)
        IDLE:    state <= accept ? REQ : IDLE;
        REQ:     state <= flush_i ? (addr_ok_i && !data_ok_i ? DRAIN : IDLE) :
                          addr_ok_i ? (data_ok_i ? DONE : WAIT) : REQ;
        WAIT:    state <= flush_i ? (data_ok_i ? IDLE : DRAIN) : data_ok_i ? DONE : WAIT;
        DONE:    state <= IDLE;
        DRAIN:   state <= data_ok_i ? IDLE : DRAIN;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of 32- and 64-bit lane instances against a byte-memory model
module tb_mem_access_unit;
  import mem_pkg::*;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic valid = 0, flush = 0, addr_ok = 0, data_ok = 0;
  mem_op_t op = NONE;
  logic [31:0] addr = 0, wdata = 0, cur_addr = 0;
  logic [7:0] mem [0:255];
  logic [31:0] brd32;
  logic [63:0] brd64;

  logic s32, rv32, el32, es32, q32, w32, s64, rv64, el64, es64, q64, w64;
  logic [31:0] r32, bv32, ba32, bw32, r64, bv64, ba64;
  logic [3:0] be32;
  logic [7:0] be64;
  logic [63:0] bw64;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) u32 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .addr_i(addr), .wdata_i(wdata),
    .flush_i(flush), .stall_o(s32), .rdata_o(r32), .rdata_valid_o(rv32), .adel_o(el32),
    .ades_o(es32), .bad_vaddr_o(bv32), .req_o(q32), .we_o(w32), .baddr_o(ba32), .be_o(be32),
    .bwdata_o(bw32), .addr_ok_i(addr_ok), .data_ok_i(data_ok), .brdata_i(brd32));

  mem_access_unit #(.ADDR_W(32), .DATA_W(64)) u64 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .addr_i(addr), .wdata_i(wdata),
    .flush_i(flush), .stall_o(s64), .rdata_o(r64), .rdata_valid_o(rv64), .adel_o(el64),
    .ades_o(es64), .bad_vaddr_o(bv64), .req_o(q64), .we_o(w64), .baddr_o(ba64), .be_o(be64),
    .bwdata_o(bw64), .addr_ok_i(addr_ok), .data_ok_i(data_ok), .brdata_i(brd64));

  // slave returns the aligned bus word around the current transfer address
  always_comb begin
    for (int i = 0; i < 8; i++) brd64[8*i +: 8] = mem[{cur_addr[7:3], 3'b000} + 8'(i)];
    for (int i = 0; i < 4; i++) brd32[8*i +: 8] = mem[{cur_addr[7:2], 2'b00} + 8'(i)];
  end

  int n_cmp = 0, n_bad = 0, stall_tot = 0, rv_tot = 0;
  logic chk_en = 0;
  logic exp_stall = 0, exp_req = 0, exp_rv = 0, exp_adel = 0, exp_ades = 0;
  logic [31:0] exp_bad = 0, exp_rdata = 0, t_addr = 0, t_wd = 0;
  mem_op_t t_op = NONE;
  logic [3:0] last_be32 = 0;
  logic [7:0] last_be64 = 0;
  logic [31:0] last_bw32 = 0;
  logic last_we32 = 0;

  function automatic int sz(mem_op_t o);
    return (o == LW || o == SW) ? 4 : (o == LH || o == LHU || o == SH) ? 2 : 1;
  endfunction
  function automatic logic is_ld(mem_op_t o);
    return o == LB || o == LBU || o == LH || o == LHU || o == LW;
  endfunction
  function automatic logic is_st(mem_op_t o);
    return o == SB || o == SH || o == SW;
  endfunction
  function automatic logic [31:0] ld_val(mem_op_t o, logic [31:0] a);
    logic [31:0] v = 0;
    for (int i = 0; i < sz(o); i++) v[8*i +: 8] = mem[a[7:0] + 8'(i)];
    if (o == LB && v[7]) v[31:8] = '1;
    if (o == LH && v[15]) v[31:16] = '1;
    return v;
  endfunction
  function automatic logic [7:0] exp_be(int nb, mem_op_t o, logic [31:0] a);
    logic [7:0] b = 0;
    for (int i = 0; i < sz(o); i++) b[(int'(a[2:0]) + i) % nb] = 1'b1;
    return b;
  endfunction
  function automatic logic [63:0] exp_bw(int nb, mem_op_t o, logic [31:0] wd);
    logic [63:0] w = 0;
    for (int l = 0; l < nb; l++) w[8*l +: 8] = wd[8*(l % sz(o)) +: 8];
    return w;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison of both instances against the expectation state
  always @(negedge clk) if (chk_en) begin
    chk("stall32", 64'(s32), 64'(exp_stall));
    chk("stall64", 64'(s64), 64'(exp_stall));
    chk("req32", 64'(q32), 64'(exp_req));
    chk("req64", 64'(q64), 64'(exp_req));
    chk("rvalid32", 64'(rv32), 64'(exp_rv));
    chk("rvalid64", 64'(rv64), 64'(exp_rv));
    chk("adel32", 64'(el32), 64'(exp_adel));
    chk("adel64", 64'(el64), 64'(exp_adel));
    chk("ades32", 64'(es32), 64'(exp_ades));
    chk("ades64", 64'(es64), 64'(exp_ades));
    chk("rdata32", 64'(r32), 64'(exp_rdata));
    chk("rdata64", 64'(r64), 64'(exp_rdata));
    if (exp_adel || exp_ades) begin
      chk("badva32", 64'(bv32), 64'(exp_bad));
      chk("badva64", 64'(bv64), 64'(exp_bad));
    end
    if (exp_req) begin
      chk("we32", 64'(w32), 64'(is_st(t_op)));
      chk("we64", 64'(w64), 64'(is_st(t_op)));
      chk("baddr32", 64'(ba32), 64'(t_addr & ~32'h3));
      chk("baddr64", 64'(ba64), 64'(t_addr & ~32'h7));
      chk("be32", 64'(be32), 64'(exp_be(4, t_op, t_addr)));
      chk("be64", 64'(be64), 64'(exp_be(8, t_op, t_addr)));
      chk("bwdata32", 64'(bw32), exp_bw(4, t_op, t_wd) & 64'hFFFF_FFFF);
      chk("bwdata64", bw64, exp_bw(8, t_op, t_wd));
    end
    if (q32) begin
      last_be32 = be32;
      last_bw32 = bw32;
      last_we32 = w32;
    end
    if (q64) last_be64 = be64;
    stall_tot += int'(s64);
    rv_tot += int'(rv64);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_exp();
    exp_stall = 0; exp_req = 0; exp_rv = 0; exp_adel = 0; exp_ades = 0;
  endtask

  task automatic idle(int n);
    valid = 0; op = NONE; flush = 0; addr_ok = 0; data_ok = 0;
    clr_exp();
    repeat (n) step();
  endtask

  task automatic acc(mem_op_t o, logic [31:0] a, logic [31:0] wd);
    valid = 1; op = o; addr = a; wdata = wd; flush = 0; addr_ok = 0; data_ok = 0;
    t_op = o; t_addr = a; t_wd = wd; cur_addr = a;
    clr_exp();
    exp_stall = 1;
    step();
    op = LW; addr = ~a; wdata = ~wd;
    exp_req = 1;
  endtask

  // areq: REQ cycles before addr_ok; nw: WAIT cycles before data_ok (-1 = same cycle as addr_ok)
  task automatic xfer(mem_op_t o, logic [31:0] a, logic [31:0] wd, int areq, int nw);
    acc(o, a, wd);
    repeat (areq) step();
    addr_ok = 1; data_ok = nw < 0; step();
    addr_ok = 0; exp_req = 0;
    if (nw >= 0) begin
      repeat (nw) step();
      data_ok = 1; step();
    end
    data_ok = 0; valid = 1; op = o; addr = a; wdata = wd;
    exp_stall = 0; exp_rv = is_ld(o);
    if (is_ld(o)) exp_rdata = ld_val(o, a);
    step();
    idle(1);
  endtask

  task automatic bad(mem_op_t o, logic [31:0] a);
    valid = 1; op = o; addr = a; clr_exp();
    exp_adel = is_ld(o); exp_ades = is_st(o); exp_bad = a;
    step();
    idle(1);
  endtask

  task automatic flush_req(mem_op_t o, logic [31:0] a);
    acc(o, a, 32'h0);
    flush = 1; exp_stall = 0; step();
    idle(2);
  endtask

  task automatic flush_drain(mem_op_t o, logic [31:0] a, logic [31:0] wd, logic in_req, logic same, int nd);
    acc(o, a, wd);
    addr_ok = 1; flush = in_req; step();
    addr_ok = 0; exp_req = 0; valid = 0; op = NONE;
    if (!in_req) begin
      flush = 1; data_ok = same; step();
    end
    flush = 0;
    if (!same) begin
      data_ok = 0; repeat (nd) step();
      data_ok = 1; step();
    end
    data_ok = 0; exp_stall = 0; step();
    idle(1);
  endtask

  task automatic rst_checks(string tag);
    chk({tag, "_stall32"}, 64'(s32), 0);   chk({tag, "_stall64"}, 64'(s64), 0);
    chk({tag, "_req32"}, 64'(q32), 0);     chk({tag, "_req64"}, 64'(q64), 0);
    chk({tag, "_we32"}, 64'(w32), 0);      chk({tag, "_we64"}, 64'(w64), 0);
    chk({tag, "_rv32"}, 64'(rv32), 0);     chk({tag, "_rv64"}, 64'(rv64), 0);
    chk({tag, "_adel"}, 64'(el32 | el64), 0);
    chk({tag, "_ades"}, 64'(es32 | es64), 0);
    chk({tag, "_baddr"}, 64'(ba32 | ba64), 0);
    chk({tag, "_be"}, 64'(be32) | 64'(be64), 0);
    chk({tag, "_bw"}, 64'(bw32) | bw64, 0);
    chk({tag, "_rdata"}, 64'(r32 | r64), 0);
    chk({tag, "_badva"}, 64'(bv32 | bv64), 0);
  endtask

  int s0, r0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);
    mem[0] = 8'h88; mem[1] = 8'h77; mem[2] = 8'h66; mem[3] = 8'h55;
    mem[4] = 8'h44; mem[5] = 8'h33; mem[6] = 8'h22; mem[7] = 8'h11;
    mem[8'h13] = 8'h80;
    repeat (2) @(posedge clk);
    #1;
    rst_checks("reset");
    rst = 0; chk_en = 1;
    idle(2);

    s0 = stall_tot; r0 = rv_tot;
    xfer(LW, 32'h1000_0004, 32'h0, 0, 0);
    chk("lw_stall_cycles", 64'(stall_tot - s0), 3);
    chk("lw_rv_pulses", 64'(rv_tot - r0), 1);
    chk("lw_be64_lit", 64'(last_be64), 64'hF0);
    chk("lw_rdata64_lit", 64'(r64), 64'h1122_3344);

    xfer(LB, 32'h1000_0013, 32'h0, 2, -1);
    chk("lb_rdata_lit", 64'(r32), 64'hFFFF_FF80);
    xfer(LBU, 32'h1000_0013, 32'h0, 0, 3);
    chk("lbu_rdata_lit", 64'(r32), 64'h0000_0080);

    r0 = rv_tot;
    xfer(SH, 32'h1000_0022, 32'h1234_ABCD, 1, 0);
    chk("sh_be32_lit", 64'(last_be32), 64'hC);
    chk("sh_bw32_lit", 64'(last_bw32), 64'hABCD_ABCD);
    chk("sh_we32_lit", 64'(last_we32), 1);
    chk("sh_no_rvalid", 64'(rv_tot - r0), 0);

    flush_req(LW, 32'h1000_0010);
    flush_drain(LW, 32'h1000_0014, 32'h0, 1'b0, 1'b0, 2);
    flush_drain(LB, 32'h1000_0031, 32'h0, 1'b0, 1'b1, 0);
    flush_drain(SW, 32'h1000_0020, 32'h5555_AAAA, 1'b1, 1'b0, 1);
    chk("flush_rdata_kept", 64'(r32), 64'h0000_0080);

    valid = 1; op = LW; addr = 32'h1000_0040; flush = 1; clr_exp();
    step();
    idle(1);

    xfer(SB, 32'h1000_0005, 32'h0000_005A, 0, 1);
    xfer(SW, 32'h1000_000C, 32'hDEAD_BEEF, 0, -1);
    xfer(LH, 32'h1000_0006, 32'h0, 1, 2);
    xfer(LHU, 32'h1000_001A, 32'h0, 0, 0);
    xfer(LH, 32'h1000_002E, 32'h0, 0, 0);
    xfer(LW, 32'h1000_0038, 32'h0, 0, 1);
    xfer(LB, 32'h1000_0007, 32'h0, 0, 0);
    xfer(SH, 32'h1000_0006, 32'hFFFF_1357, 0, 0);

    bad(LW, 32'h1000_0002);
    bad(SH, 32'h1000_0003);
    bad(LH, 32'h1000_0001);
    bad(SW, 32'h1000_0006);
    bad(LHU, 32'h1000_0005);

    acc(LW, 32'h1000_0008, 32'h0);
    addr_ok = 1; step();
    chk_en = 0; addr_ok = 0; valid = 0; op = NONE;
    #2 rst = 1;
    #1 rst_checks("async_rst");
    @(posedge clk);
    #1;
    rst = 0; clr_exp(); exp_rdata = 0; chk_en = 1;
    step();
    xfer(LW, 32'h1000_0004, 32'h0, 0, 0);
    chk("post_rst_lw_lit", 64'(r64), 64'h1122_3344);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle load/store engine for the MEM stage of the MIPS pipeline; successor to the single-cycle RAM port path.
- Drives an SRAM-like split-handshake bus: request/address phase, then a data phase.
- Stalls the pipeline while a transfer is in flight.
- Flags AdEL/AdES alignment exceptions, and cancels or drains transfers on pipeline flush.
- Parametrised in address width and bus data width (32- or 64-bit lanes).

Parameters:
- ADDR_W, 32, virtual/physical address width.
- DATA_W, 32, bus data width; legal values 32 or 64; byte lanes = DATA_W/8.
- LANE_BITS, $clog2(DATA_W/8), derived; address bits selecting the byte lane.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- valid_i  in  1  MEM-stage instruction is a memory access.
- op_i  in  4  mem_op_t: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- addr_i  in  ADDR_W  effective address.
- wdata_i  in  32  store data (rt).
- flush_i  in  1  exception/eret flush from commit.
- stall_o  out  1  hold MEM and all earlier stages.
- rdata_o  out  32  sign/zero-extended load result.
- rdata_valid_o  out  1  one-cycle pulse when rdata_o holds a new load result.
- adel_o  out  1  load address error.
- ades_o  out  1  store address error.
- bad_vaddr_o  out  ADDR_W  faulting address.
- req_o  out  1  bus request.
- we_o  out  1  bus write.
- baddr_o  out  ADDR_W  lane-aligned address (low LANE_BITS zero).
- be_o  out  DATA_W/8  byte enables.
- bwdata_o  out  DATA_W  store data replicated across lanes.
- addr_ok_i  in  1  slave accepted request.
- data_ok_i  in  1  data phase complete.
- brdata_i  in  DATA_W  read data.

Behaviour:
- Interface: one clock clk_i; reset rst_i is asynchronous and active-high.
- Reset state: FSM=IDLE. stall_o, req_o, we_o, rdata_valid_o, adel_o and ades_o are 0. All buses (baddr_o, be_o, bwdata_o, rdata_o, bad_vaddr_o) are 0.
- Reset mid-transfer: FSM returns to IDLE immediately; the bus slave is reset by the same rst_i.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- Alignment check (combinational, IDLE only, when valid_i is high):
  - LH, LHU, SH require addr_i[0]=0.
  - LW, SW require addr_i[1:0]=0.
  - On violation: adel_o (loads) or ades_o (stores) = 1 and bad_vaddr_o = addr_i in the same cycle. No request is issued, stall_o=0, FSM stays IDLE.
- IDLE:
  - Accept condition: valid_i & op_i!=NONE & aligned & !flush_i.
  - On accept: stall_o=1 combinationally; latch op, addr, byte enables and lane-shifted data; go to REQ.
- REQ:
  - req_o=1; we_o and be_o come from the latched op.
  - Byte enables: byte = 1 bit, half = 2 bits, word = 4 bits, shifted to addr[LANE_BITS-1:0].
  - addr_ok_i & data_ok_i in the same cycle -> DONE.
  - addr_ok_i only -> WAIT.
  - flush_i & !addr_ok_i -> withdraw request, go to IDLE, stall_o=0.
  - flush_i & addr_ok_i -> DRAIN (takes precedence over WAIT).
- WAIT:
  - req_o=0, stall_o=1.
  - data_ok_i -> DONE; a load captures brdata_i here.
  - flush_i -> DRAIN; if data_ok_i is also high, go straight to IDLE and discard the data.
- DONE (exactly 1 cycle):
  - stall_o=0; rdata_valid_o=1 for loads only.
  - valid_i is ignored (the same instruction is still presented).
  - Next state is IDLE.
- DRAIN:
  - stall_o=1; wait for data_ok_i, discard it, go to IDLE.
  - No new request is issued; the bus never has more than 1 outstanding transfer.
- Load extraction: select the lane byte/half/word by the latched low address bits; LB/LH sign-extend, LBU/LHU zero-extend.
- rdata_o holds its value until the next load's DONE.
- Stores write the lane-shifted data; bwdata_o replicates the byte or half across the whole bus.
- Best-case timing: accept at T; req_o at T+1 with addr_ok_i; data_ok_i at T+2 gives DONE at T+3. That is 3 stall cycles (T..T+2).
- Inputs need not stay stable after accept, because all of them are latched.

Decomposition:
- Package mem_pkg holds:
  - mem_op_t enum;
  - mem_state_t enum;
  - functions is_load, is_store, access_size.
- One sub-module: mem_lane_align.
  - Combinational.
  - Produces be/bwdata for stores from op, low address bits and data.
  - Produces the extended rdata for loads from op, low address bits and bus word.
  - Parametrised by DATA_W.

Test Plan:
- LW addr 0x1000_0004, DATA_W=64, slave addr_ok at T+1, data_ok at T+2, brdata=0x1122_3344_5566_7788 -> be_o=0xF0, rdata_o=0x1122_3344, rdata_valid_o pulses at T+3, stall_o high T..T+2.
- LB addr 0x...03, DATA_W=32, byte 0x80 -> rdata_o=0xFFFF_FF80. LBU on the same access -> 0x0000_0080.
- SH addr 0x...02, wdata_i=0xABCD -> be_o=4'b1100, bwdata_o=0xABCD_ABCD, we_o=1, rdata_valid_o stays 0.
- LW addr 0x...02 -> adel_o=1 and bad_vaddr_o=addr the same cycle, req_o never asserted, stall_o=0. SH at an odd address -> ades_o=1.
- Flush cases:
  - flush_i in REQ with addr_ok_i=0 -> req_o drops next cycle, IDLE.
  - flush_i in WAIT -> DRAIN; stall_o held until data_ok_i; data discarded, rdata_o unchanged.
- Assert rst_i in WAIT -> all outputs 0 asynchronously, FSM IDLE. After release, a new LW completes normally.
